// File: rtl/spi_peripheral.sv
// SPI responder: oversampled SCLK/CS_N/MOSI, 16-bit address+data frames, LSB first.
// Optional address-incrementing bursts are enabled by defining SPI_PERIPHERAL_BURST_EN.
module spi_peripheral #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        IDLE_MISO   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_sclk,
  input  logic       i_cs_n,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe,
  output logic       o_wr_valid,
  output logic [6:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_rd_req,
  output logic [6:0] o_rd_addr,
  input  logic [7:0] i_rd_data,
  output logic       o_busy,
  output logic       o_frame_err
);

  typedef enum logic [2:0] {
    StWaitCsHigh, StIdle, StAddr, StWrData, StRdData, StDrain
  } state_e;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_prev, r_cs_prev;
  logic                   w_sclk_s, w_cs_s, w_mosi_s, w_sclk_rise, w_sclk_fall, w_cs_fall;

  // cs_n resets to "asserted" so a frame already in flight is never joined.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
  assign w_cs_fall   = ~w_cs_s & r_cs_prev;

  state_e     r_state, w_state_next;
  logic [2:0] r_cnt, w_cnt_next;
  logic [7:0] r_shift, w_shift_next;
  logic [6:0] r_addr, w_addr_next;
  logic       r_boundary, w_boundary_next;
  logic       r_rd_capture, w_rd_capture_next;
  logic       r_miso, w_miso_next, r_miso_oe, w_miso_oe_next;
  logic       r_wr_valid, w_wr_valid_next, r_rd_req, w_rd_req_next;
  logic [6:0] r_wr_addr, w_wr_addr_next, r_rd_addr, w_rd_addr_next;
  logic [7:0] r_wr_data, w_wr_data_next;
  logic       r_busy, w_busy_next, r_frame_err, w_frame_err_next;
  logic [7:0] w_byte;

  assign w_byte = {w_mosi_s, r_shift[7:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StWaitCsHigh;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_addr       <= '0;
      r_boundary   <= 1'b0;
      r_rd_capture <= 1'b0;
      r_miso       <= IDLE_MISO;
      r_miso_oe    <= 1'b0;
      r_wr_valid   <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_rd_req     <= 1'b0;
      r_rd_addr    <= '0;
      r_busy       <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_shift      <= w_shift_next;
      r_addr       <= w_addr_next;
      r_boundary   <= w_boundary_next;
      r_rd_capture <= w_rd_capture_next;
      r_miso       <= w_miso_next;
      r_miso_oe    <= w_miso_oe_next;
      r_wr_valid   <= w_wr_valid_next;
      r_wr_addr    <= w_wr_addr_next;
      r_wr_data    <= w_wr_data_next;
      r_rd_req     <= w_rd_req_next;
      r_rd_addr    <= w_rd_addr_next;
      r_busy       <= w_busy_next;
      r_frame_err  <= w_frame_err_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_shift_next      = r_shift;
    w_addr_next       = r_addr;
    w_boundary_next   = r_boundary;
    w_rd_capture_next = 1'b0;
    w_miso_next       = r_miso;
    w_miso_oe_next    = r_miso_oe;
    w_wr_valid_next   = 1'b0;
    w_wr_addr_next    = r_wr_addr;
    w_wr_data_next    = r_wr_data;
    w_rd_req_next     = 1'b0;
    w_rd_addr_next    = r_rd_addr;
    w_busy_next       = r_busy;
    w_frame_err_next  = 1'b0;
    // Read data is valid exactly one clk after the rd_req pulse.
    if (r_rd_capture) w_shift_next = i_rd_data;

    unique case (r_state)
      StWaitCsHigh: if (w_cs_s) w_state_next = StIdle;
      StIdle: begin
        if (w_cs_fall) begin
          w_state_next    = StAddr;
          w_busy_next     = 1'b1;
          w_cnt_next      = '0;
          w_boundary_next = 1'b0;
        end
      end
      StAddr, StWrData, StRdData: begin
        if (w_cs_s) begin
          // A deselect between whole burst bytes is a normal end, not an abort.
          w_frame_err_next = ~r_boundary;
          w_state_next     = StIdle;
          w_busy_next      = 1'b0;
          w_miso_oe_next   = 1'b0;
          w_miso_next      = IDLE_MISO;
          w_boundary_next  = 1'b0;
        end else if (r_state == StAddr) begin
          if (w_sclk_fall) begin
            w_shift_next = w_byte;
            w_cnt_next   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              w_addr_next = w_byte[6:0];
              if (w_byte[7]) begin
                w_state_next = StWrData;
              end else begin
                w_rd_addr_next    = w_byte[6:0];
                w_rd_req_next     = 1'b1;
                w_rd_capture_next = 1'b1;
                w_miso_oe_next    = 1'b1;
                w_state_next      = StRdData;
              end
            end
          end
        end else if (r_state == StWrData) begin
          if (w_sclk_fall) begin
            w_shift_next    = w_byte;
            w_cnt_next      = r_cnt + 3'd1;
            w_boundary_next = 1'b0;
            if (r_cnt == 3'd7) begin
              w_wr_valid_next = 1'b1;
              w_wr_addr_next  = r_addr;
              w_wr_data_next  = w_byte;
`ifdef SPI_PERIPHERAL_BURST_EN
              w_addr_next     = r_addr + 7'd1;
              w_boundary_next = 1'b1;
`else
              w_state_next    = StDrain;
`endif
            end
          end
        end else begin
          if (w_sclk_rise) begin
            w_miso_next     = r_shift[0];
            w_shift_next    = {1'b0, r_shift[7:1]};
            w_boundary_next = 1'b0;
`ifdef SPI_PERIPHERAL_BURST_EN
            if (r_cnt == 3'd7) begin
              w_addr_next       = r_addr + 7'd1;
              w_rd_addr_next    = r_addr + 7'd1;
              w_rd_req_next     = 1'b1;
              w_rd_capture_next = 1'b1;
            end
`endif
          end
          if (w_sclk_fall) begin
            w_cnt_next = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
`ifdef SPI_PERIPHERAL_BURST_EN
              w_boundary_next = 1'b1;
`else
              w_miso_oe_next  = 1'b0;
              w_miso_next     = IDLE_MISO;
              w_state_next    = StDrain;
`endif
            end
          end
        end
      end
      StDrain: begin
        if (w_cs_s) begin
          w_state_next = StIdle;
          w_busy_next  = 1'b0;
        end
      end
      default: w_state_next = StWaitCsHigh;
    endcase
  end

  assign o_miso      = r_miso;
  assign o_miso_oe   = r_miso_oe;
  assign o_wr_valid  = r_wr_valid;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_rd_req    = r_rd_req;
  assign o_rd_addr   = r_rd_addr;
  assign o_busy      = r_busy;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: write/read scoreboards fed by the stimulus,
// drained by a strobe monitor; frames are bit-banged at a chosen sclk half-period.
module tb_spi_peripheral;
  localparam int unsigned SyncStages = 2;
  localparam logic        IdleMiso   = 1'b0;
`ifdef SPI_PERIPHERAL_BURST_EN
  localparam bit Burst = 1'b1;
`else
  localparam bit Burst = 1'b0;
`endif
  localparam int RdPerRead = Burst ? 2 : 1;

  typedef struct packed {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset, sclk, cs_n, mosi, miso, miso_oe, wr_valid, rd_req, busy, frame_err;
  logic [6:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data, rd_value;

  int         n_checks = 0, n_errors = 0;
  int         n_wr = 0, n_rd = 0, n_ferr = 0;
  bit         saw_oe = 1'b0;
  wr_t        wr_q[$];
  logic [6:0] rd_q[$];
  logic [7:0] miso_q[$];

  always #5 clk = ~clk;

  spi_peripheral #(
    .SYNC_STAGES(SyncStages),
    .IDLE_MISO  (IdleMiso)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_sclk     (sclk),
    .i_cs_n     (cs_n),
    .i_mosi     (mosi),
    .o_miso     (miso),
    .o_miso_oe  (miso_oe),
    .o_wr_valid (wr_valid),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_rd_req   (rd_req),
    .o_rd_addr  (rd_addr),
    .i_rd_data  (rd_data),
    .o_busy     (busy),
    .o_frame_err(frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: pops scoreboards, answers reads for exactly one clk.
  always @(negedge clk) begin
    wr_t        ew;
    logic [6:0] ea;
    if (wr_valid || rd_req) check("wr_rd_exclusive", {31'd0, wr_valid & rd_req}, 32'd0);
    if (wr_valid) begin
      n_wr++;
      check("wr_q_nonempty", {31'd0, wr_q.size() != 0}, 32'd1);
      if (wr_q.size() != 0) begin
        ew = wr_q.pop_front();
        check("wr_addr", {25'd0, wr_addr}, {25'd0, ew.a});
        check("wr_data", {24'd0, wr_data}, {24'd0, ew.d});
      end
    end
    if (rd_req) begin
      n_rd++;
      check("rd_q_nonempty", {31'd0, rd_q.size() != 0}, 32'd1);
      if (rd_q.size() != 0) begin
        ea = rd_q.pop_front();
        check("rd_addr", {25'd0, rd_addr}, {25'd0, ea});
      end
      rd_data = rd_value;
    end else begin
      rd_data = ~rd_value;
    end
    if (frame_err) n_ferr++;
    if (miso_oe) saw_oe = 1'b1;
  end

  task automatic send_bit(input logic b, input int half, output logic miso_at_fall);
    mosi = b;
    sclk = 1'b1;
    repeat (half) @(negedge clk);
    miso_at_fall = miso;
    sclk = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  task automatic frame(input logic [23:0] bits, input int nbits, input int half,
                       output logic [7:0] rx, output logic oe_end, output logic miso_end,
                       output logic busy_mid);
    logic m;
    rx       = '0;
    busy_mid = 1'b0;
    cs_n     = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      send_bit(bits[i], half, m);
      if (i >= 8 && i < 16) rx[i-8] = m;
      if (i == 4) busy_mid = busy;
    end
    oe_end   = miso_oe;
    miso_end = miso;
    cs_n     = 1'b1;
    repeat (2 * half) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rx;
    logic       oe_end, miso_end, busy_mid, m;
    int         wr0, ferr0;

    reset    = 1'b1;
    sclk     = 1'b0;
    cs_n     = 1'b1;
    mosi     = 1'b0;
    rd_value = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_miso", {31'd0, miso}, {31'd0, IdleMiso});
    check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_wr_addr", {25'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_rd_req", {31'd0, rd_req}, 32'd0);
    check("rst_rd_addr", {25'd0, rd_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Write 0x85/0xA7.
    wr_q.push_back('{a: 7'h05, d: 8'hA7});
    saw_oe = 1'b0;
    frame(24'h00A785, 16, 8, rx, oe_end, miso_end, busy_mid);
    check("wr1_busy_mid", {31'd0, busy_mid}, 32'd1);
    check("wr1_count", n_wr, 1);
    check("wr1_no_oe", {31'd0, saw_oe}, 32'd0);
    check("wr1_no_ferr", n_ferr, 0);
    check("wr1_busy_end", {31'd0, busy}, 32'd0);

    // Read 0x12 returning 0x3C.
    rd_value = 8'h3C;
    rd_q.push_back(7'h12);
    if (Burst) rd_q.push_back(7'h13);
    miso_q.push_back(8'h3C);
    frame(24'h000012, 16, 8, rx, oe_end, miso_end, busy_mid);
    check("rd1_miso_byte", {24'd0, rx}, {24'd0, miso_q.pop_front()});
    check("rd1_count", n_rd, RdPerRead);
    check("rd1_oe_last", {31'd0, oe_end}, {31'd0, Burst});
    check("rd1_miso_last", {31'd0, miso_end}, {31'd0, Burst ? 1'b0 : IdleMiso});
    check("rd1_oe_after", {31'd0, miso_oe}, 32'd0);
    check("rd1_rd_addr_held", {25'd0, rd_addr}, {25'd0, Burst ? 7'h13 : 7'h12});
    check("rd1_wr_count", n_wr, 1);

    // Abort after 11 bits of a write, then a clean write 0x81/0x55.
    frame(24'h00FF83, 11, 8, rx, oe_end, miso_end, busy_mid);
    check("abort_ferr", n_ferr, 1);
    check("abort_no_wr", n_wr, 1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    wr_q.push_back('{a: 7'h01, d: 8'h55});
    frame(24'h005581, 16, 8, rx, oe_end, miso_end, busy_mid);
    check("wr2_count", n_wr, 2);

    // Reset pulsed mid-frame with cs_n held low.
    wr0   = n_wr;
    ferr0 = n_ferr;
    cs_n  = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 8, m);
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_wr_addr", {25'd0, wr_addr}, 32'd0);
    check("mid_rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("mid_rst_rd_addr", {25'd0, rd_addr}, 32'd0);
    check("mid_rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    for (int i = 0; i < 11; i++) send_bit(1'b1, 8, m);
    cs_n = 1'b1;
    repeat (16) @(negedge clk);
    check("mid_no_wr", n_wr, wr0);
    check("mid_no_ferr", n_ferr, ferr0);
    check("mid_busy_ignored", {31'd0, busy}, 32'd0);
    wr_q.push_back('{a: 7'h00, d: 8'hFF});
    frame(24'h00FF80, 16, 8, rx, oe_end, miso_end, busy_mid);
    check("wr3_count", n_wr, wr0 + 1);

    // 24 clocks on a write; bursts add a second byte, including 0x7F->0x00 wrap.
    wr0 = n_wr;
    wr_q.push_back('{a: 7'h00, d: 8'h11});
    if (Burst) wr_q.push_back('{a: 7'h01, d: 8'h22});
    frame(24'h221180, 24, 8, rx, oe_end, miso_end, busy_mid);
    wr_q.push_back('{a: 7'h7F, d: 8'h11});
    if (Burst) wr_q.push_back('{a: 7'h00, d: 8'h22});
    frame(24'h2211FF, 24, 8, rx, oe_end, miso_end, busy_mid);
    check("burst_wr_count", n_wr, wr0 + (Burst ? 4 : 2));
    check("burst_no_ferr", n_ferr, ferr0);

    // Minimum half-period read of 0x7F returning 0x01.
    rd_value = 8'h01;
    rd_q.push_back(7'h7F);
    if (Burst) rd_q.push_back(7'h00);
    miso_q.push_back(8'h01);
    frame(24'h00007F, 16, int'(SyncStages) + 4, rx, oe_end, miso_end, busy_mid);
    check("rd2_miso_byte", {24'd0, rx}, {24'd0, miso_q.pop_front()});
    check("rd2_count", n_rd, 2 * RdPerRead);
    check("rd2_rd_addr", {25'd0, rd_addr}, {25'd0, Burst ? 7'h00 : 7'h7F});
    check("rd2_oe_after", {31'd0, miso_oe}, 32'd0);

    check("wr_q_drained", wr_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    check("final_ferr", n_ferr, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
- SPI responder (target) for the team's SPI controller; one instance per chip-select line.
- Oversamples SCLK/CS_N/MOSI in the system clk domain and decodes 16-bit frames: address byte, then data byte.
- Write frames emit a one-cycle write strobe to local logic. Read frames fetch a byte from local logic and shift it out on MISO.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers for sclk, cs_n and mosi (minimum 2).
- IDLE_MISO, 0, level driven on miso while miso_oe is low.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- sclk  input  1  SPI clock, asynchronous to clk, CPOL=0.
- cs_n  input  1  chip select, active-low, asynchronous.
- mosi  input  1  serial data in, LSB first.
- miso  output  1  serial data out, LSB first.
- miso_oe  output  1  high while a read data byte is being shifted.
- wr_valid  output  1  one-cycle pulse: write frame completed.
- wr_addr  output  7  address of the completed write.
- wr_data  output  8  data of the completed write.
- rd_req  output  1  one-cycle pulse: read data needed.
- rd_addr  output  7  address for rd_req; held until the next rd_req.
- rd_data  input  8  read data; sampled exactly 1 clk after rd_req.
- busy  output  1  high from frame start until return to IDLE.
- frame_err  output  1  one-cycle pulse: frame aborted (cs_n rose early).

Behaviour:
- Reset values: miso=IDLE_MISO, miso_oe=0, wr_valid=0, wr_addr=0, wr_data=0, rd_req=0, rd_addr=0, busy=0, frame_err=0. All counters clear; state=WAIT_CS_HIGH.
- Synchronization: sclk, cs_n and mosi each pass through SYNC_STAGES flops. Edges are detected on the synchronized sclk.
- Bus rule: mosi is sampled on sclk falling edges; miso is updated on sclk rising edges.
- Timing requirement: sclk half-period >= SYNC_STAGES+4 clk cycles. Slower sclk is always tolerated.
- Bit counter is 3 bits, 0..7. Bit i of each byte is the i-th bit sampled (LSB first).
- FSM states: WAIT_CS_HIGH, IDLE, ADDR, WR_DATA, RD_DATA, DRAIN.
- WAIT_CS_HIGH: entered after reset. Moves to IDLE once synchronized cs_n=1, so the block never joins a frame mid-stream.
- IDLE: on synchronized cs_n falling -> ADDR, busy=1, bit counter=0.
- ADDR: shifts in 8 bits. Bit 7 is the write flag; bits 6:0 are the address.
  - On the 8th falling edge with flag=1: latch address -> WR_DATA.
  - On the 8th falling edge with flag=0: rd_addr=address, pulse rd_req, capture rd_data next clk into the shift register, miso_oe=1 -> RD_DATA.
- WR_DATA: shifts in 8 bits. On the 8th falling edge: wr_addr and wr_data updated, wr_valid pulses on the same clk -> DRAIN.
- RD_DATA: on each sclk rising edge, miso = shift[0], then shift right.
  - The first rising edge after entry presents bit 0.
  - After the 8th bit has been held through its falling edge: miso_oe=0, miso=IDLE_MISO -> DRAIN.
- DRAIN: ignores further sclk edges; on cs_n high -> IDLE, busy=0.
- Early abort: cs_n high while in ADDR, WR_DATA or RD_DATA -> frame_err pulses once; no wr_valid; miso_oe=0; -> IDLE.
  - If rd_req already fired, the read is not retracted.
- cs_n falling and an sclk edge on the same clk: the frame start wins; that sclk edge is ignored.
- Reset asserted mid-frame: all outputs return to reset values; -> WAIT_CS_HIGH.
- wr_valid and rd_req are never high in the same cycle. At most one of them fires per frame.

Optional Feature:
- Macro: SPI_PERIPHERAL_BURST_EN.
- Defined:
  - In DRAIN-equivalent points, a continued clock with cs_n low starts the next data byte at address+1 (7-bit wrap 127->0), same direction as the frame.
  - Write bursts: wr_valid pulses per byte.
  - Read bursts: rd_req is issued at the 8th rising edge of the current byte for the next address.
- Not defined: bits beyond 16 are ignored (DRAIN), exactly as described above.

Test Plan:
- Write frame addr 0x85 (write, addr 0x05), data 0xA7, sclk half-period 8 clk -> one wr_valid with wr_addr=0x05, wr_data=0xA7; miso_oe stays 0; frame_err never pulses.
- Read frame addr 0x12, bench returns rd_data=0x3C one clk after rd_req -> rd_addr=0x12, single rd_req; miso bits sampled on falling edges = 0,0,1,1,1,1,0,0; miso_oe falls after the 8th bit.
- cs_n raised after 11 bits of a write frame -> frame_err pulses once, no wr_valid. A following write of 0x81/0x55 -> wr_valid with addr 0x01, data 0x55.
- Reset pulsed mid-frame with cs_n held low -> outputs reset; remaining bits ignored (no strobes). After cs_n high/low, a new write of 0x80/0xFF -> wr_valid, wr_data=0xFF.
- 24 clocks on a write frame 0x80/0x11/0x22 -> without burst: one wr_valid (addr 0, data 0x11). With SPI_PERIPHERAL_BURST_EN: second wr_valid (addr 1, data 0x22). Burst from addr 0x7F wraps to addr 0x00.
- Minimum sclk half-period SYNC_STAGES+4 on a read of addr 0x7F with rd_data=0x01 -> miso bit 0 = 1 on the first falling edge, remaining bits 0.
